// File: rtl/col_ofifo.sv
// Per-column output capture FIFOs behind the MAC row. Columns fill independently
// to absorb diagonal skew. A full aligned vector is presented and popped all at once.
module col_ofifo #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_overflow,
    output logic [psum_bw*col-1:0] out
);

    localparam int aw = $clog2(depth);
    localparam logic [aw:0] ptr_one = {{aw{1'b0}}, 1'b1};

    logic [aw:0]        wp [col];
    logic [aw:0]        rp;
    logic [psum_bw-1:0] mem [col][depth];
    logic [col-1:0]     empty;
    logic [col-1:0]     full;
    logic [col-1:0]     accept;
    logic               pop;

    always_comb begin
        empty = '0;
        full  = '0;
        for (int i = 0; i < col; i++) begin
            empty[i] = (wp[i] == rp);
            full[i]  = (wp[i][aw-1:0] == rp[aw-1:0]) && (wp[i][aw] != rp[aw]);
        end
    end

    assign o_valid = ~|empty;
    assign o_full  = |full;
    assign pop     = rd & o_valid;
    // A pop this cycle frees the slot the write lands in, so a full column still accepts.
    assign accept  = wr & (~full | {col{pop}});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rp         <= '0;
            o_overflow <= 1'b0;
            for (int i = 0; i < col; i++) begin
                wp[i] <= '0;
            end
        end else begin
            if (pop) begin
                rp <= rp + ptr_one;
            end
            for (int i = 0; i < col; i++) begin
                if (accept[i]) begin
                    wp[i] <= wp[i] + ptr_one;
                end
            end
            if (|(wr & ~accept)) begin
                o_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < col; i++) begin
            if (accept[i]) begin
                mem[i][wp[i][aw-1:0]] <= in[psum_bw*i +: psum_bw];
            end
        end
    end

    for (genvar g = 0; g < col; g++) begin : g_out
        assign out[psum_bw*g +: psum_bw] = o_valid ? mem[g][rp[aw-1:0]] : '0;
    end

endmodule
